// File: rtl/fac8_round_sat.sv
// Round/saturate output stage for the FAC8 datapath: drives block addresses to the
// twiddle-multiply stage and rounds its 4 x DEPTH lanes from <10.13> down to <7.6>.

module fac8_round_sat_lane #(
    parameter int DIN_WIDTH  = 23,
    parameter int DOUT_WIDTH = 13,
    parameter int SHIFT      = 7
) (
    input  logic signed [DIN_WIDTH-1:0]  x,
    output logic signed [DOUT_WIDTH-1:0] y,
    output logic                         sat
);
    localparam int SW = DIN_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DOUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] q;

    // One guard bit keeps the half-LSB add from overflowing at full scale.
    always_comb begin
        sum = {x[DIN_WIDTH-1], x} + HALF;
        q   = sum >>> SHIFT;
        sat = 1'b0;
        y   = q[DOUT_WIDTH-1:0];
        if (q > MAXV) begin
            y   = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            sat = 1'b1;
        end else if (q < MINV) begin
            y   = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            sat = 1'b1;
        end
    end
endmodule

module fac8_round_sat #(
    parameter int DIN_WIDTH  = 23,
    parameter int DOUT_WIDTH = 13,
    parameter int SHIFT      = 7,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_BLK    = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     dout_ready,
    input  logic signed [DEPTH-1:0][DIN_WIDTH-1:0]   din_R_add,
    input  logic signed [DEPTH-1:0][DIN_WIDTH-1:0]   din_Q_add,
    input  logic signed [DEPTH-1:0][DIN_WIDTH-1:0]   din_R_sub,
    input  logic signed [DEPTH-1:0][DIN_WIDTH-1:0]   din_Q_sub,
    output logic                                     en_out,
    output logic        [ADDR_WIDTH-1:0]             addr_out,
    output logic signed [DEPTH-1:0][DOUT_WIDTH-1:0]  dout_R_add,
    output logic signed [DEPTH-1:0][DOUT_WIDTH-1:0]  dout_Q_add,
    output logic signed [DEPTH-1:0][DOUT_WIDTH-1:0]  dout_R_sub,
    output logic signed [DEPTH-1:0][DOUT_WIDTH-1:0]  dout_Q_sub,
    output logic                                     dout_valid,
    output logic                                     sof,
    output logic                                     eof,
    output logic                                     busy,
    output logic                                     sat_flag,
    output logic        [7:0]                        sat_cnt
);
    localparam int BLK_W = $clog2(NUM_BLK);
    localparam int NS    = 4 * DEPTH;
    localparam int CW    = $clog2(NS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [BLK_W-1:0]               blk_cnt;
    logic [1:0]                     vld_pipe;
    logic                           v1;
    logic                           first1, last1;
    logic                           stall, start_acc, last_issue;
    logic [NS-1:0][DIN_WIDTH-1:0]   x_all;
    logic [NS-1:0][DOUT_WIDTH-1:0]  y_all;
    logic [NS-1:0]                  sat_all;
    logic [CW-1:0]                  sat_beat;
    logic [8:0]                     sat_sum;

    assign v1         = vld_pipe[0];
    assign dout_valid = vld_pipe[1];
    assign stall      = dout_valid && !dout_ready;
    assign en_out     = (state == RUN) && !stall;
    assign busy       = (state != IDLE);
    assign start_acc  = (state == IDLE) && start;
    assign last_issue = en_out && (blk_cnt == BLK_W'(NUM_BLK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (dout_valid && dout_ready && eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane order in the flattened vector: R_add, Q_add, R_sub, Q_sub from index 0 up.
    assign x_all = {din_Q_sub, din_R_sub, din_Q_add, din_R_add};

    for (genvar i = 0; i < NS; i++) begin : g_lane
        fac8_round_sat_lane #(
            .DIN_WIDTH (DIN_WIDTH),
            .DOUT_WIDTH(DOUT_WIDTH),
            .SHIFT     (SHIFT)
        ) u_lane (
            .x  (x_all[i]),
            .y  (y_all[i]),
            .sat(sat_all[i])
        );
    end

    always_comb begin
        sat_beat = '0;
        for (int i = 0; i < NS; i++) sat_beat = sat_beat + CW'(sat_all[i]);
        sat_sum = {1'b0, sat_cnt} + 9'(sat_beat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out   <= '0;
            blk_cnt    <= '0;
            vld_pipe   <= '0;
            first1     <= 1'b0;
            last1      <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            dout_R_add <= '0;
            dout_Q_add <= '0;
            dout_R_sub <= '0;
            dout_Q_sub <= '0;
            sat_flag   <= 1'b0;
            sat_cnt    <= '0;
        end else begin
            if (start_acc) begin
                addr_out <= '0;
                blk_cnt  <= '0;
            end else if (en_out) begin
                addr_out <= addr_out + ADDR_WIDTH'(DEPTH);
                blk_cnt  <= blk_cnt + BLK_W'(1);
            end

            // The whole pipe freezes on stall so a held beat is never lost or repeated.
            if (!stall) begin
                vld_pipe   <= {v1, en_out};
                first1     <= en_out && (blk_cnt == '0);
                last1      <= last_issue;
                sof        <= v1 && first1;
                eof        <= v1 && last1;
                dout_R_add <= y_all[DEPTH-1:0];
                dout_Q_add <= y_all[2*DEPTH-1:DEPTH];
                dout_R_sub <= y_all[3*DEPTH-1:2*DEPTH];
                dout_Q_sub <= y_all[4*DEPTH-1:3*DEPTH];
            end

            if (start_acc) begin
                sat_flag <= 1'b0;
                sat_cnt  <= '0;
            end else if (!stall && v1) begin
                if (sat_beat != '0) sat_flag <= 1'b1;
                sat_cnt <= (sat_sum > 9'd255) ? 8'd255 : sat_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_fac8_round_sat.sv
// Bench for fac8_round_sat: emulates the multiply stage, scores every beat against
// an arithmetic rounding model, and exercises reset, backpressure and start-ignore.

module tb_fac8_round_sat;
    localparam int DW = 23, OW = 13, DEPTH = 16, NB = 32;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dout_ready = 1'b1;
    logic signed [DEPTH-1:0][DW-1:0] din_R_add, din_Q_add, din_R_sub, din_Q_sub;
    logic en_out, dout_valid, sof, eof, busy, sat_flag;
    logic [8:0] addr_out;
    logic [7:0] sat_cnt;
    logic signed [DEPTH-1:0][OW-1:0] dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub;

    fac8_round_sat dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dout_ready(dout_ready),
        .din_R_add(din_R_add), .din_Q_add(din_Q_add), .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
        .en_out(en_out), .addr_out(addr_out),
        .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add), .dout_R_sub(dout_R_sub), .dout_Q_sub(dout_Q_sub),
        .dout_valid(dout_valid), .sof(sof), .eof(eof), .busy(busy),
        .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; bit s; } vec_t;
    vec_t vec [12];

    int n_chk = 0, n_pass = 0;
    int fd [NB][4][DEPTH];
    int exp_y [NB][4][DEPTH];
    int exp_cnt [NB];
    int cap [NB][4][DEPTH];

    int gcyc = 0, mon_beat = 0, iss = 0, first_en = -1, last_en = -1, first_v = -1;
    bit prev_stall = 0, prev_eofacc = 0, frame_active = 0;
    logic [4*DEPTH*OW-1:0] prev_d;
    logic [8:0] prev_addr;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, gcyc);
    endtask

    // floor((x + 64) / 128), clamped to the 13-bit signed range
    task automatic ref_rs(input int x, output int y, output bit s);
        longint t, q;
        t = longint'(x) + 64;
        q = (t >= 0) ? t / 128 : -((-t + 127) / 128);
        s = (q > 4095) || (q < -4096);
        y = (q > 4095) ? 4095 : (q < -4096) ? -4096 : int'(q);
    endtask

    task automatic build_expect();
        int cnt, y;
        bit s;
        cnt = 0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < DEPTH; l++) begin
                    ref_rs(fd[b][k][l], y, s);
                    exp_y[b][k][l] = y;
                    if (s) cnt++;
                end
            if (cnt > 255) cnt = 255;
            exp_cnt[b] = cnt;
        end
    endtask

    task automatic fill_rand();
        int r;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < DEPTH; l++) begin
                    r = int'($urandom);
                    fd[b][k][l] = ($urandom_range(0, 1) != 0) ? ((r <<< 9) >>> 9) : ((r <<< 9) >>> 14);
                end
    endtask

    task automatic fill_sat();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < DEPTH; l++)
                    fd[b][k][l] = ($urandom_range(0, 1) != 0) ? 4194303 - int'($urandom_range(0, 1000))
                                                              : -4194304 + int'($urandom_range(0, 1000));
    endtask

    task automatic drive(input int b);
        for (int l = 0; l < DEPTH; l++) begin
            din_R_add[l] = DW'(fd[b][0][l]);
            din_Q_add[l] = DW'(fd[b][1][l]);
            din_R_sub[l] = DW'(fd[b][2][l]);
            din_Q_sub[l] = DW'(fd[b][3][l]);
        end
    endtask

    function automatic int dout_get(input int k, input int l);
        case (k)
            0:       return int'($signed(dout_R_add[l]));
            1:       return int'($signed(dout_Q_add[l]));
            2:       return int'($signed(dout_R_sub[l]));
            default: return int'($signed(dout_Q_sub[l]));
        endcase
    endfunction

    task automatic check_beat();
        bit ok;
        int a, ba, be;
        ok = 1; ba = 0; be = 0;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < DEPTH; l++) begin
                a = dout_get(k, l);
                cap[mon_beat][k][l] = a;
                if (ok && a != exp_y[mon_beat][k][l]) begin
                    ok = 0; ba = a; be = exp_y[mon_beat][k][l];
                end
            end
        chk("beat_data", ok, ba, be);
        chk("sof", sof == (mon_beat == 0), sof, mon_beat == 0);
        chk("eof", eof == (mon_beat == NB - 1), eof, mon_beat == NB - 1);
        chk("sat_cnt", sat_cnt == 8'(exp_cnt[mon_beat]), sat_cnt, exp_cnt[mon_beat]);
        chk("sat_flag", sat_flag == (exp_cnt[mon_beat] != 0), sat_flag, exp_cnt[mon_beat] != 0);
        mon_beat++;
    endtask

    always @(negedge clk) begin
        gcyc++;
        if (frame_active && rst_n) begin
            if (prev_eofacc) chk("busy_after_eof", !busy, busy, 0);
            if (prev_stall) begin
                chk("hold_dout", {dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub} == prev_d, 1, 0);
                chk("hold_addr", addr_out == prev_addr, addr_out, prev_addr);
            end
            if (dout_valid && !dout_ready) chk("en_in_stall", !en_out, en_out, 0);
            if (en_out) begin
                chk("addr", addr_out == 9'(iss * DEPTH), addr_out, iss * DEPTH);
                if (first_en < 0) first_en = gcyc;
                last_en = gcyc;
                iss++;
            end
            if (!dout_valid) chk("sof_eof_idle", !sof && !eof, {sof, eof}, 0);
            else if (first_v < 0) first_v = gcyc;
            if (dout_valid && dout_ready) begin
                if (mon_beat < NB) check_beat();
                else chk("extra_beat", 0, mon_beat, NB - 1);
            end
            prev_stall  = dout_valid && !dout_ready;
            prev_eofacc = dout_valid && dout_ready && eof;
            prev_d      = {dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub};
            prev_addr   = addr_out;
        end
    end

    // rmode: 0 always ready, 1 three-cycle stall on beat 5, 2 random ready
    task automatic run_frame(input int rmode, input bit start_ign);
        int cyc, lb, hc, b_s;
        bit did, en_s, done;
        cyc = 0; lb = 0; hc = 0; b_s = 0; did = 0; en_s = 0; done = 0;
        build_expect();
        @(posedge clk); #1;
        mon_beat = 0; iss = 0; first_en = -1; last_en = -1; first_v = -1;
        prev_stall = 0; prev_eofacc = 0; frame_active = 1;
        start = 1; dout_ready = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            en_s = en_out;
            b_s  = int'(addr_out) / DEPTH;
            if (dout_valid && dout_ready) lb++;
            @(posedge clk); #1;
            cyc++;
            if (en_s) drive(b_s);
            if (rmode == 1 && lb == 5 && !did) begin hc = 3; did = 1; end
            if (hc > 0) begin dout_ready = 0; hc--; end
            else if (rmode == 2) dout_ready = ($urandom_range(0, 3) != 0);
            else dout_ready = 1;
            start = start_ign && (cyc == 10 || (dout_valid && eof && dout_ready));
            if (!busy) done = 1;
        end
        chk("frame_done", done, cyc, 400);
        start = 0; dout_ready = 1;
        @(negedge clk); #1;
        frame_active = 0;
        chk("beat_count", mon_beat == NB, mon_beat, NB);
        chk("issue_count", iss == NB, iss, NB);
        if (rmode == 0) begin
            chk("en_run", last_en - first_en == NB - 1, last_en - first_en, NB - 1);
            chk("latency", first_v - first_en == 2, first_v - first_en, 2);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        bit ok;
        ok = 1;
        repeat (n) begin
            @(negedge clk);
            if (busy || dout_valid || en_out) ok = 0;
        end
        chk(tag, ok, {busy, dout_valid, en_out}, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, {dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub} == '0, 1, 0);
        chk({tag, "_ctrl"}, {en_out, dout_valid, sof, eof, busy, sat_flag} == 6'b0,
            {en_out, dout_valid, sof, eof, busy, sat_flag}, 0);
        chk({tag, "_addr"}, addr_out == 9'd0, addr_out, 0);
        chk({tag, "_satcnt"}, sat_cnt == 8'd0, sat_cnt, 0);
    endtask

    task automatic mid_reset();
        bit en_s;
        int b_s;
        fill_sat();
        @(posedge clk); #1;
        start = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en_s = en_out;
            b_s  = int'(addr_out) / DEPTH;
            @(posedge clk); #1;
            start = 0;
            if (en_s) drive(b_s);
        end
        chk("pre_rst_active", busy && dout_valid && sat_flag, {busy, dout_valid, sat_flag}, 7);
        #2 rst_n = 0;
        #1 chk_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1;
        idle_check("post_rst_idle", 10);
    endtask

    initial begin
        int sat_exp;
        vec[0]  = '{64, 1, 0};        vec[1]  = '{63, 0, 0};
        vec[2]  = '{-64, 0, 0};       vec[3]  = '{-65, -1, 0};
        vec[4]  = '{191, 1, 0};       vec[5]  = '{192, 2, 0};
        vec[6]  = '{4194303, 4095, 1}; vec[7] = '{-4194304, -4096, 1};
        vec[8]  = '{524223, 4095, 0}; vec[9]  = '{-524288, -4096, 0};
        vec[10] = '{0, 0, 0};         vec[11] = '{-1, 0, 0};

        din_R_add = '0; din_Q_add = '0; din_R_sub = '0; din_Q_sub = '0;
        #12 chk_zero("rst");
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) @(posedge clk);

        // Directed vectors in block 0, lane j of R_add; everything else zero.
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < DEPTH; l++) fd[b][k][l] = 0;
        sat_exp = 0;
        for (int j = 0; j < 12; j++) begin
            fd[0][0][j] = vec[j].x;
            if (vec[j].s) sat_exp++;
        end
        run_frame(0, 0);
        for (int j = 0; j < 12; j++)
            chk($sformatf("vec_%0d", vec[j].x), cap[0][0][j] == vec[j].y, cap[0][0][j], vec[j].y);
        chk("vec_sat_cnt", sat_cnt == 8'(sat_exp), sat_cnt, sat_exp);
        chk("vec_sat_flag", sat_flag == (sat_exp != 0), sat_flag, sat_exp != 0);

        fill_rand();
        run_frame(1, 0);

        fill_sat();
        run_frame(2, 0);
        chk("sat_stick", sat_cnt == 8'd255 && sat_flag, sat_cnt, 255);

        fill_rand();
        run_frame(0, 1);
        idle_check("start_ignored_idle", 8);

        mid_reset();

        fill_rand();
        run_frame(2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
